// File: rtl/gpu_vga_pkg.sv
// Shared GPU-to-VGA definitions: pixel width, default raster geometry,
// the span record and the pixel streamer's decision states.
package gpu_vga_pkg;

  localparam int PIX_W        = 6;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_X_W      = 10;

  typedef struct packed {
    logic [DEF_X_W-1:0] x0;
    logic [DEF_X_W-1:0] x1;
    logic [PIX_W-1:0]   color;
    logic               last;
  } span_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CLOSED = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/span_fifo.sv
// Synchronous FIFO for packed span records; show-ahead read of the head entry.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module span_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & !o_empty;
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_data  = r_mem[r_rd];

  // NOTE: storage is left unreset; the count alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/span_pixel_streamer.sv
// Expands per-line colour spans into a raster-ordered pixel stream with a
// valid/ready output register, background fill and line/frame done pulses.
module span_pixel_streamer
  import gpu_vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int X_W        = DEF_X_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_20,
  input  logic             reset,
  input  logic [PIX_W-1:0] bg_color,
  input  logic             span_valid,
  output logic             span_ready,
  input  logic [X_W-1:0]   span_x0,
  input  logic [X_W-1:0]   span_x1,
  input  logic [PIX_W-1:0] span_color,
  input  logic             span_last,
  input  logic             vga_ready_in,
  output logic             vga_data_valid_out,
  output logic [PIX_W-1:0] vga_data_out,
  output logic             line_done,
  output logic             frame_done
);

  localparam int             Y_W    = $clog2(V_ACTIVE);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  typedef struct packed {
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   x1;
    logic [PIX_W-1:0] color;
    logic             last;
  } span_lt;

  span_lt           w_push_span;
  span_lt           w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_accept;
  logic             w_emit;
  logic             w_eol_x;
  logic [X_W-1:0]   w_x1_eff;
  logic [PIX_W-1:0] w_pix;
  state_t           w_state_nxt;

  state_t           r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_valid;
  logic [PIX_W-1:0] r_data;
  logic             r_eol;
  logic             r_eof;
  logic             r_line_done;
  logic             r_frame_done;

  assign span_ready  = !w_full;
  assign w_push      = span_valid & !w_full;
  assign w_push_span = '{x0: span_x0, x1: span_x1, color: span_color, last: span_last};

  span_fifo #(
    .W     ($bits(span_lt)),
    .DEPTH (FIFO_DEPTH)
  ) u_span_fifo (
    .i_clk   (clk_20),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (w_push_span),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_load   = !r_valid | vga_ready_in;
  assign w_accept = r_valid & vga_ready_in;
  assign w_eol_x  = (r_x == X_LAST);
  // Spans running past the visible line end are clipped to its last pixel.
  assign w_x1_eff = (w_head.x1 > X_LAST) ? X_LAST : w_head.x1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_pix       = bg_color;
    case (r_state)
      ST_FLUSH: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.last) w_state_nxt = ST_RUN;
        end
      end
      ST_CLOSED: w_emit = w_load;
      ST_RUN: begin
        if (w_load && !w_empty) begin
          if ((w_head.x0 > w_head.x1) || (w_x1_eff < r_x)) begin
            w_pop = 1'b1;
            if (w_head.last) w_state_nxt = ST_CLOSED;
          end else if (r_x < w_head.x0) begin
            w_emit = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_pix  = w_head.color;
            if (r_x == w_x1_eff) begin
              w_pop = 1'b1;
              if (w_head.last) w_state_nxt = ST_CLOSED;
            end
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    // Ending a line whose last span was never consumed leaves its leftovers to flush.
    if (w_emit && w_eol_x) begin
      w_state_nxt = ((r_state == ST_CLOSED) || (w_pop && w_head.last)) ? ST_RUN : ST_FLUSH;
    end
  end

  always_ff @(posedge clk_20 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_x          <= '0;
      r_y          <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_line_done  <= w_accept & r_eol;
      r_frame_done <= w_accept & r_eof;
      if (w_load) begin
        r_valid <= w_emit;
        if (w_emit) begin
          r_data <= w_pix;
          r_eol  <= w_eol_x;
          r_eof  <= w_eol_x && (r_y == Y_LAST);
        end
      end
      if (w_emit) begin
        if (w_eol_x) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
    end
  end

  assign vga_data_valid_out = r_valid;
  assign vga_data_out       = r_data;
  assign line_done          = r_line_done;
  assign frame_done         = r_frame_done;

endmodule

// File: tb/tb_span_pixel_streamer.sv
// Bench for span_pixel_streamer: directed and random span lines, random
// backpressure, compared against a span-level reference model of each line.
module tb_span_pixel_streamer;

  localparam int H  = 640;
  localparam int V  = 6;
  localparam int XW = 10;

  logic       clk_20 = 1'b0;
  logic       reset  = 1'b1;
  logic [5:0] bg_color = '0;
  logic       span_valid = 1'b0;
  logic       span_ready;
  logic [9:0] span_x0 = '0;
  logic [9:0] span_x1 = '0;
  logic [5:0] span_color = '0;
  logic       span_last = 1'b0;
  logic       vga_ready_in = 1'b1;
  logic       vga_data_valid_out;
  logic [5:0] vga_data_out;
  logic       line_done;
  logic       frame_done;

  span_pixel_streamer #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .X_W        (XW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_20             (clk_20),
    .reset              (reset),
    .bg_color           (bg_color),
    .span_valid         (span_valid),
    .span_ready         (span_ready),
    .span_x0            (span_x0),
    .span_x1            (span_x1),
    .span_color         (span_color),
    .span_last          (span_last),
    .vga_ready_in       (vga_ready_in),
    .vga_data_valid_out (vga_data_valid_out),
    .vga_data_out       (vga_data_out),
    .line_done          (line_done),
    .frame_done         (frame_done)
  );

  always #25 clk_20 = ~clk_20;

  typedef struct {
    int x0;
    int x1;
    int color;
    bit last;
    int wait_px;
    int gap;
  } tspan_t;

  tspan_t line_q[$];
  int     exp_pix[H];
  int     n_acc;
  int     tb_y;
  int     n_vec;
  int     n_miss;
  int     bubbles;
  int     max_stall;
  int     frame_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tspan_t mk(int x0, int x1, int color, bit last, int wait_px = 0, int gap = 0);
    tspan_t s;
    s.x0 = x0; s.x1 = x1; s.color = color; s.last = last;
    s.wait_px = wait_px; s.gap = gap;
    return s;
  endfunction

  // Reference: spans paint left to right; each covers [max(x0,cur), min(x1,H-1)],
  // anything left of cur is lost, the line ends at the last span or at pixel H-1.
  function automatic void build_expected(input int bg);
    int cur, lo, hi;
    cur = 0;
    for (int i = 0; i < line_q.size(); i++) begin
      if (line_q[i].x0 <= line_q[i].x1) begin
        lo = line_q[i].x0;
        hi = (line_q[i].x1 > H - 1) ? H - 1 : line_q[i].x1;
        if (hi >= cur) begin
          for (int x = cur; x <= hi; x++) exp_pix[x] = (x < lo) ? bg : line_q[i].color;
          cur = hi + 1;
        end
      end
      if (line_q[i].last || cur >= H) break;
    end
    for (int x = cur; x < H; x++) exp_pix[x] = bg;
  endfunction

  task automatic rand_line();
    int n, x0, x1;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      x0 = $urandom_range(0, 660);
      case ($urandom_range(0, 7))
        0:       x1 = (x0 > 0) ? x0 - 1 : 0;
        1:       x1 = $urandom_range(640, 1023);
        default: x1 = x0 + $urandom_range(0, 160);
      endcase
      if (x1 > 1023) x1 = 1023;
      line_q.push_back(mk(x0, x1, $urandom_range(0, 63), i == n - 1));
    end
  endtask

  task automatic produce(input bit rnd);
    int     budget;
    bit     acc;
    tspan_t s;
    budget = 20000;
    while (line_q.size() > 0 && budget > 0) begin
      s = line_q.pop_front();
      while (n_acc < s.wait_px && budget > 0) begin
        @(negedge clk_20);
        span_valid = 1'b0;
        budget--;
      end
      repeat (s.gap) begin
        @(negedge clk_20);
        span_valid = 1'b0;
      end
      acc = 1'b0;
      while (!acc && budget > 0) begin
        @(negedge clk_20);
        budget--;
        span_x0    = XW'(s.x0);
        span_x1    = XW'(s.x1);
        span_color = 6'(s.color);
        span_last  = s.last;
        span_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        acc        = span_valid && span_ready;
      end
    end
    @(negedge clk_20);
    span_valid = 1'b0;
    if (budget <= 0) check("produce_timeout", 32'(budget), 32'd1);
  endtask

  task automatic consume(input int stop_n, input bit rnd);
    int         budget, run;
    bit         hold, exp_ld, exp_fd;
    logic [5:0] pdata;
    budget = 20000; run = 0; hold = 0; exp_ld = 0; exp_fd = 0; pdata = '0;
    bubbles = 0; max_stall = 0;
    while (n_acc < stop_n && budget > 0) begin
      @(negedge clk_20);
      budget--;
      check("line_done", 32'(line_done), 32'(exp_ld));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done === 1'b1) frame_cnt++;
      if (hold) begin
        check("hold_valid", 32'(vga_data_valid_out), 32'd1);
        check("hold_data", 32'(vga_data_out), 32'(pdata));
      end
      vga_ready_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      exp_ld = 0;
      exp_fd = 0;
      if (vga_data_valid_out && vga_ready_in) begin
        check($sformatf("pix_y%0d_x%0d", tb_y, n_acc), 32'(vga_data_out), 32'(exp_pix[n_acc]));
        if (n_acc == H - 1) begin
          exp_ld = 1;
          exp_fd = (tb_y == V - 1);
        end
        n_acc++;
        run = 0;
      end else if (!vga_data_valid_out && n_acc > 0) begin
        bubbles++;
        run++;
        if (run > max_stall) max_stall = run;
      end
      if (vga_data_valid_out) run = 0;
      hold  = vga_data_valid_out && !vga_ready_in;
      pdata = vga_data_out;
    end
    if (budget <= 0) check("consume_timeout", 32'(n_acc), 32'(stop_n));
    if (n_acc == H) begin
      @(negedge clk_20);
      check("line_done_end", 32'(line_done), 32'(exp_ld));
      check("frame_done_end", 32'(frame_done), 32'(exp_fd));
      if (frame_done === 1'b1) frame_cnt++;
      tb_y = (tb_y + 1) % V;
    end
  endtask

  task automatic run_line(input int bg, input bit rnd, input int stop_n);
    bg_color = 6'(bg);
    build_expected(bg);
    n_acc = 0;
    fork
      produce(rnd);
      consume(stop_n, rnd);
    join
    if (stop_n == H) begin
      repeat (3) @(negedge clk_20);
      check("idle_valid", 32'(vga_data_valid_out), 32'd0);
      check("idle_span_ready", 32'(span_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(vga_data_valid_out), 32'd0);
    check({tag, "_data"}, 32'(vga_data_out), 32'd0);
    check({tag, "_line_done"}, 32'(line_done), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_span_ready"}, 32'(span_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; tb_y = 0; frame_cnt = 0; n_acc = 0;
    repeat (2) @(negedge clk_20);
    check_reset_outputs("por");
    reset = 1'b0;

    // Single span over a black background, full-rate sink.
    line_q.push_back(mk(10, 19, 6'h3F, 1'b1));
    run_line(6'h00, 1'b0, H);
    check("s1_bubbles", 32'(bubbles), 32'd0);

    // Same line under random backpressure and a bursty span source.
    line_q.push_back(mk(10, 19, 6'h3F, 1'b1));
    run_line(6'h00, 1'b1, H);

    // Spans on the first and last pixel only.
    line_q.push_back(mk(0, 0, 6'h01, 1'b0));
    line_q.push_back(mk(639, 639, 6'h02, 1'b1));
    run_line(6'h15, 1'b0, H);
    check("s3_bubbles", 32'(bubbles), 32'd0);

    // Empty span closes the line immediately.
    line_q.push_back(mk(5, 4, 6'h2A, 1'b1));
    run_line(6'h0C, 1'b0, H);
    check("s4_bubbles", 32'(bubbles), 32'd0);

    // Source starves for 20 cycles after pixel 99.
    line_q.push_back(mk(0, 99, 6'h30, 1'b0));
    line_q.push_back(mk(200, 299, 6'h0F, 1'b1, 100, 20));
    run_line(6'h03, 1'b0, H);
    check("s5_stall_ge20", 32'(max_stall >= 20), 32'd1);

    // Random lines through the end of frame 0 and all of frame 1, then y=0 of frame 2.
    for (int i = 0; i < 8; i++) begin
      rand_line();
      run_line($urandom_range(0, 63), 1'b1, H);
    end

    // Abandon line y=1 at x=300 with reset.
    line_q.push_back(mk(0, 639, 6'h21, 1'b1));
    run_line(6'h00, 1'b1, 300);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(negedge clk_20);
    check("mid_line_done_hold", 32'(line_done), 32'd0);
    check("mid_frame_done_hold", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tb_y = 0;
    vga_ready_in = 1'b1;

    // A full fresh frame after reset.
    for (int i = 0; i < V; i++) begin
      rand_line();
      run_line($urandom_range(0, 63), 1'b1, H);
    end
    check("frame_pulse_count", 32'(frame_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
